// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//
// Stream handshake: a byte moves on a rising clock edge where in_valid and
// in_ready are both 1. in_valid must not depend on in_ready. in_byte is held
// stable while in_valid is 1 and in_ready is 0.
//
// Memory write: one word is written on each rising edge where wr_en is 1.
// There is no back-pressure from memory.
interface imem_program_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // The environment side: it supplies the stream and sinks the writes.
  modport master (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // The loader side.
  modport slave (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Packs an 8-bit byte stream into 32-bit words, MSB first. It writes the words
// to consecutive addresses starting at 0 and stops after the halt word. It then
// raises cpu_run. If the memory fills without a halt word, the load ends in ERR.
//
// Optional feature: define LOADER_CHECKSUM_EN to keep a running XOR of every
// written word on 'checksum'. Without it, checksum is tied to zero and no
// register is built.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 LOAD, 2 WRITE, 3 DONE, 4 ERR.
module imem_program_loader #(
  parameter int          ADDR_W    = 11,
  parameter int          DATA_W    = 32,            // must be 32: four bytes per word
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  imem_program_loader_if.slave  bus,
  output logic [ADDR_W:0]       word_count,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  cpu_run,
  output logic [31:0]           checksum,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [1:0]        byte_cnt_q;   // bytes already packed into the current word
  logic [ADDR_W-1:0] ptr_q;        // address of the next word to be written
  logic [DATA_W-1:0] shreg_q;      // word under assembly, oldest byte ends up on top
  logic [ADDR_W:0]   wcount_q;     // words written in this load, halt word included

  logic              in_ready_c;
  logic              write_cyc;    // WRITE state: memory strobe is live
  logic              byte_take;    // a byte handshake completes this cycle
  logic              clear_load;   // start accepted: begin a fresh load at address 0
  logic              advance;      // non-final word written, move to the next address
  logic              ptr_last;
  logic              is_halt;

  assign ptr_last = &ptr_q;
  assign is_halt  = (shreg_q == HALT_WORD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    write_cyc  = 1'b0;
    byte_take  = 1'b0;
    clear_load = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // in_ready stays low, so a byte presented alongside start is not taken.
        if (start) begin
          clear_load = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // start is ignored mid-load. A byte handshake in that cycle still counts.
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          byte_take = 1'b1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // Exactly one cycle. This is the bubble between consecutive words.
        write_cyc = 1'b1;
        if (is_halt) begin
          state_d = ST_DONE;
        end else if (ptr_last) begin
          // The pointer never wraps. The top address was the last legal write.
          state_d = ST_ERR;
        end else begin
          advance = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          clear_load = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Byte packing, word pointer and written-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      ptr_q      <= '0;
      shreg_q    <= '0;
      wcount_q   <= '0;
    end else if (clear_load) begin
      byte_cnt_q <= 2'd0;
      ptr_q      <= '0;
      shreg_q    <= '0;
      wcount_q   <= '0;
    end else begin
      if (byte_take) begin
        // The 2-bit counter rolls over to 0 on the fourth byte. The next word
        // therefore starts clean without a separate clear.
        shreg_q    <= {shreg_q[DATA_W-9:0], bus.in_byte};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (write_cyc) begin
        wcount_q <= wcount_q + 1'b1;
      end
      if (advance) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running XOR of every word driven onto the write port in this load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (clear_load) begin
      checksum_q <= '0;
    end else if (write_cyc) begin
      checksum_q <= checksum_q ^ shreg_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

  // Outputs are decoded straight from state. Every output is 0 in IDLE. The
  // memory strobe and cpu_run come from disjoint states, so they never overlap.
  assign bus.in_ready = in_ready_c;
  assign bus.wr_en    = write_cyc;
  assign bus.wr_addr  = ptr_q;
  assign bus.wr_data  = shreg_q;
  assign word_count   = wcount_q;
  assign load_done    = (state_q == ST_DONE);
  assign cpu_run      = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERR);
  assign state_dbg    = state_q;

  // Invariants of the write port and the pipeline release.
  a_run_excl_wr : assert property (@(posedge clk) disable iff (!rst_n)
                                   bus.wr_en |-> !cpu_run);
  a_wr_in_write : assert property (@(posedge clk) disable iff (!rst_n)
                                   bus.wr_en |-> (state_q == ST_WRITE));
  a_done_err    : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(load_done && load_err));

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader. Writes seen on the memory port are
// logged on the falling edge and compared with an expected queue of
// {address, data} entries that each scenario builds by hand.
module tb_imem_program_loader;
  localparam int ADDR_W = 11;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [31:0] CK_PROG = 32'hFF9F_F7FF;  // 00232021 ^ 00432821 ^ FFFFFFFF
  localparam logic [31:0] CK_HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] CK_BEEF = 32'h2152_4110;  // DEADBEEF ^ FFFFFFFF
  localparam logic [31:0] CK_1234 = 32'hEDCB_A987;  // 12345678 ^ FFFFFFFF
`else
  localparam logic [31:0] CK_PROG = 32'h0;
  localparam logic [31:0] CK_HALT = 32'h0;
  localparam logic [31:0] CK_BEEF = 32'h0;
  localparam logic [31:0] CK_1234 = 32'h0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              load_done;
  logic              load_err;
  logic              cpu_run;
  logic [31:0]       checksum;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] obs_q[$];

  imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_run    (cpu_run),
    .checksum   (checksum),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // write monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  // ---------------- driver tasks (all return at posedge + 1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    int guard;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    taken = 0;
    guard = 0;
    while (!taken && guard < 50) begin
      @(negedge clk);
      taken = (bus.in_ready === 1'b1);
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted in 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], int'($urandom_range(max_gap, 0)));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.wr_en, load_done, load_err, cpu_run} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.in_ready, bus.wr_en, load_done, load_err, cpu_run});
    end
    checks++;
    if ({word_count, bus.wr_addr, bus.wr_data, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_values: got wc=%0d addr=%h data=%h ck=%h expected all 0",
               word_count, bus.wr_addr, bus.wr_data, checksum);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.in_valid = 1'b1;  // no start: the byte must not be accepted in IDLE
    bus.in_byte  = 8'h5A;
    tick();
    @(negedge clk);
    checks++;
    if ({state_dbg, bus.in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got state=%0d in_ready=%b expected 0/0", state_dbg, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    @(negedge clk);
    checks++;
    if ({state_dbg, bus.in_ready} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL load_entry: got state=%0d in_ready=%b expected 1/1", state_dbg, bus.in_ready);
    end
    tick();
    send_word(32'h0023_2021, 0);
    // one cycle after the fourth handshake: write strobe live, stream stalled
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.in_ready, bus.wr_addr, bus.wr_data} !== {1'b1, 1'b0, 11'd0, 32'h0023_2021}) begin
      errors++;
      $display("FAIL first_write: got wr_en=%b in_ready=%b addr=%h data=%h expected 1/0/000/00232021",
               bus.wr_en, bus.in_ready, bus.wr_addr, bus.wr_data);
    end
    tick();
    send_word(32'h0043_2821, 0);
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    // stream still offered in DONE must not be taken
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    exp_q.push_back({11'd0, 32'h0023_2021});
    exp_q.push_back({11'd1, 32'h0043_2821});
    exp_q.push_back({11'd2, 32'hFFFF_FFFF});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({word_count, load_done, cpu_run, load_err, bus.in_ready, state_dbg} !== {12'd3, 4'b1100, 3'd3}) begin
      errors++;
      $display("FAIL basic_done: got wc=%0d done=%b run=%b err=%b rdy=%b st=%0d expected 3/1/1/0/0/3",
               word_count, load_done, cpu_run, load_err, bus.in_ready, state_dbg);
    end
    checks++;
    if (checksum !== CK_PROG) begin
      errors++;
      $display("FAIL basic_checksum: got %h expected %h", checksum, CK_PROG);
    end
  endtask

  task automatic test_random_gaps();
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    checks++;
    if ({load_done, cpu_run, bus.in_ready, word_count, checksum} !== {3'b001, 12'd0, 32'h0}) begin
      errors++;
      $display("FAIL restart_clear: got done=%b run=%b rdy=%b wc=%0d ck=%h expected 0/0/1/0/0",
               load_done, cpu_run, bus.in_ready, word_count, checksum);
    end
    send_word(32'h0023_2021, 5);
    send_word(32'h0043_2821, 5);
    send_word(32'hFFFF_FFFF, 5);
    repeat (2) tick();
    exp_q.push_back({11'd0, 32'h0023_2021});
    exp_q.push_back({11'd1, 32'h0043_2821});
    exp_q.push_back({11'd2, 32'hFFFF_FFFF});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gaps_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gaps_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({word_count, load_done, cpu_run, checksum} !== {12'd3, 2'b11, CK_PROG}) begin
      errors++;
      $display("FAIL gaps_done: got wc=%0d done=%b run=%b ck=%h expected 3/1/1/%h",
               word_count, load_done, cpu_run, checksum, CK_PROG);
    end
  endtask

  task automatic test_restart();
    exp_q.delete();
    obs_q.delete();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_done, cpu_run} !== 2'b11) begin
      errors++;
      $display("FAIL restart_before_edge: got done=%b run=%b expected 1/1", load_done, cpu_run);
    end
    tick();
    start = 1'b0;
    checks++;
    if ({load_done, cpu_run, state_dbg} !== {2'b00, 3'd1}) begin
      errors++;
      $display("FAIL restart_drop: got done=%b run=%b st=%0d expected 0/0/1", load_done, cpu_run, state_dbg);
    end
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    exp_q.push_back({11'd0, 32'hFFFF_FFFF});
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL restart_write: got %0d writes first %h expected 1 write %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
    checks++;
    if ({word_count, load_done, cpu_run, checksum} !== {12'd1, 2'b11, CK_HALT}) begin
      errors++;
      $display("FAIL restart_done: got wc=%0d done=%b run=%b ck=%h expected 1/1/1/%h",
               word_count, load_done, cpu_run, checksum, CK_HALT);
    end
  endtask

  task automatic test_start_ignored();
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    // start together with a byte in LOAD: byte taken, start ignored
    start = 1'b1;
    bus.in_byte  = 8'hBE;
    bus.in_valid = 1'b1;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    send_byte(8'hEF, 0);
    // now in WRITE: start here must not restart the load
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    exp_q.push_back({11'd0, 32'hDEAD_BEEF});
    exp_q.push_back({11'd1, 32'hFFFF_FFFF});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ignore_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({word_count, load_done, checksum} !== {12'd2, 1'b1, CK_BEEF}) begin
      errors++;
      $display("FAIL ignore_done: got wc=%0d done=%b ck=%h expected 2/1/%h",
               word_count, load_done, checksum, CK_BEEF);
    end
  endtask

  task automatic test_start_with_valid_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    obs_q.delete();
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    start = 1'b0;
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    exp_q.push_back({11'd0, 32'h1234_5678});
    exp_q.push_back({11'd1, 32'hFFFF_FFFF});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL idle_start_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL idle_start_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({word_count, load_done, checksum} !== {12'd2, 1'b1, CK_1234}) begin
      errors++;
      $display("FAIL idle_start_done: got wc=%0d done=%b ck=%h expected 2/1/%h",
               word_count, load_done, checksum, CK_1234);
    end
  endtask

  task automatic test_reset_mid_load();
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_dbg, bus.wr_en, word_count, bus.in_ready} !== '0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d wr_en=%b wc=%0d rdy=%b expected all 0",
               state_dbg, bus.wr_en, word_count, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write: got %0d writes expected 0", obs_q.size());
    end
    pulse_start();
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {11'd0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL reset_reload_write: got %0d writes first %h expected 1 write %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, {11'd0, 32'hFFFF_FFFF});
    end
    checks++;
    if ({word_count, load_done, cpu_run} !== {12'd1, 2'b11}) begin
      errors++;
      $display("FAIL reset_reload_done: got wc=%0d done=%b run=%b expected 1/1/1",
               word_count, load_done, cpu_run);
    end
  endtask

  task automatic test_fill_error();
    int bad;
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 2048; i++) begin
      send_word(32'(i), 0);
      exp_q.push_back({11'(i), 32'(i)});
    end
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 2048) begin
      errors++;
      $display("FAIL fill_write_count: got %0d expected 2048", obs_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 4) $display("FAIL fill_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_writes: got %0d wrong entries expected 0", bad);
    end
    checks++;
    if ({load_err, load_done, cpu_run, bus.in_ready, state_dbg} !== {4'b1000, 3'd4}) begin
      errors++;
      $display("FAIL fill_err_flags: got err=%b done=%b run=%b rdy=%b st=%0d expected 1/0/0/0/4",
               load_err, load_done, cpu_run, bus.in_ready, state_dbg);
    end
    checks++;
    if ({word_count, checksum} !== {12'd2048, 32'h0}) begin
      errors++;
      $display("FAIL fill_count: got wc=%0d ck=%h expected 2048/00000000", word_count, checksum);
    end
    // recover from ERR with a fresh one-word load
    obs_q.delete();
    pulse_start();
    checks++;
    if ({load_err, word_count, bus.in_ready} !== {1'b0, 12'd0, 1'b1}) begin
      errors++;
      $display("FAIL err_restart: got err=%b wc=%0d rdy=%b expected 0/0/1", load_err, word_count, bus.in_ready);
    end
    send_word(32'hFFFF_FFFF, 0);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {11'd0, 32'hFFFF_FFFF} || load_done !== 1'b1) begin
      errors++;
      $display("FAIL err_reload: got %0d writes done=%b expected 1 write at 0 done=1", obs_q.size(), load_done);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_load();
    test_random_gaps();
    test_restart();
    test_start_ignored();
    test_start_with_valid_idle();
    test_reset_mid_load();
    test_fill_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
